// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and the register-read consumer.
// master: the surrounding pipeline (drives fetch side, accepts decoded output).
// slave:  the decode stage itself.
interface decode_stage_if #(
    parameter int OPINFO_W = 60
) ();

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_insn;
    logic [31:0]         in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [OPINFO_W-1:0] out_opinfo;
    logic [31:0]         out_pc;
    logic                out_illegal;
    logic                out_is_muldiv;
    logic                out_is_system;

    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_opinfo, out_pc,
        input  out_illegal, out_is_muldiv, out_is_system
    );

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_opinfo, out_pc,
        output out_illegal, out_is_muldiv, out_is_system
    );

endinterface

// File: rtl/decode_stage.sv
// Buffered RV32I decode stage: a DEPTH-entry instruction/PC FIFO feeding a
// decoder whose result is captured in a registered output stage.
//
// out_opinfo layout (MSB first, 60 bits):
//   rd[59:55] rs1[54:50] rs2[49:45] imm[44:13] funct3[12:10] aluAlt[9]
//   regWrEnable[8] isALUInImm[7] isLoad[6] isStore[5] isBranch[4]
//   isJal[3] isJalr[2] isLui[1] isAuipc[0]
module decode_stage #(
    parameter int DEPTH         = 4,
    parameter int ENABLE_M      = 1,
    parameter int ENABLE_SYSTEM = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    decode_stage_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        aluAlt;
        logic        regWrEnable;
        logic        isALUInImm;
        logic        isLoad;
        logic        isStore;
        logic        isBranch;
        logic        isJal;
        logic        isJalr;
        logic        isLui;
        logic        isAuipc;
    } OpInfo;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // FIFO storage and bookkeeping
    logic [31:0]      mem_insn [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;

    // Output register
    logic             out_valid_q;
    OpInfo            out_op_q;
    logic [31:0]      out_pc_q;
    logic             out_ill_q;
    logic             out_md_q;
    logic             out_sys_q;

    // Handshake
    logic             push;
    logic             load;
    logic             fifo_full;

    // Decoder results for the head entry
    logic [31:0]      head_insn;
    logic [31:0]      head_pc;
    OpInfo            dec_op;
    logic             dec_ill;
    logic             dec_md;
    logic             dec_sys;

    // Field slices of the head instruction
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       f_rd;
    logic [4:0]       f_rs1;
    logic [4:0]       f_rs2;
    logic [31:0]      imm_i;
    logic [31:0]      imm_s;
    logic [31:0]      imm_b;
    logic [31:0]      imm_u;
    logic [31:0]      imm_j;
    logic [31:0]      imm_sh;

    // in_ready depends on registered occupancy only, keeping out_ready off the fetch path
    assign fifo_full = (cnt_q == CNT_W'(DEPTH));
    assign push      = bus.in_valid && !fifo_full;
    assign load      = (!out_valid_q || bus.out_ready) && (cnt_q != '0);

    assign head_insn = mem_insn[rd_ptr];
    assign head_pc   = mem_pc[rd_ptr];

    assign opc    = head_insn[6:0];
    assign f3     = head_insn[14:12];
    assign f7     = head_insn[31:25];
    assign f_rd   = head_insn[11:7];
    assign f_rs1  = head_insn[19:15];
    assign f_rs2  = head_insn[24:20];
    assign imm_i  = {{20{head_insn[31]}}, head_insn[31:20]};
    assign imm_s  = {{20{head_insn[31]}}, head_insn[31:25], head_insn[11:7]};
    assign imm_b  = {{19{head_insn[31]}}, head_insn[31], head_insn[7],
                     head_insn[30:25], head_insn[11:8], 1'b0};
    assign imm_u  = {head_insn[31:12], 12'b0};
    assign imm_j  = {{11{head_insn[31]}}, head_insn[31], head_insn[19:12],
                     head_insn[20], head_insn[30:21], 1'b0};
    assign imm_sh = {27'b0, head_insn[24:20]};

    // Port mapping
    assign bus.in_ready      = !fifo_full;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_opinfo    = out_op_q;
    assign bus.out_pc        = out_pc_q;
    assign bus.out_illegal   = out_ill_q;
    assign bus.out_is_muldiv = out_md_q;
    assign bus.out_is_system = out_sys_q;
    assign count             = cnt_q;

    // Decode the FIFO head; any illegal encoding collapses the record to zero
    always_comb begin
        dec_op  = '0;
        dec_ill = 1'b0;
        dec_md  = 1'b0;
        dec_sys = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec_op.rd          = f_rd;
                dec_op.imm         = imm_u;
                dec_op.regWrEnable = 1'b1;
                dec_op.isALUInImm  = 1'b1;
                dec_op.isLui       = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op.rd          = f_rd;
                dec_op.imm         = imm_u;
                dec_op.regWrEnable = 1'b1;
                dec_op.isALUInImm  = 1'b1;
                dec_op.isAuipc     = 1'b1;
            end
            OPC_JAL: begin
                dec_op.rd          = f_rd;
                dec_op.imm         = imm_j;
                dec_op.regWrEnable = 1'b1;
                dec_op.isJal       = 1'b1;
            end
            OPC_JALR: begin
                dec_ill            = (f3 != 3'd0);
                dec_op.rd          = f_rd;
                dec_op.rs1         = f_rs1;
                dec_op.imm         = imm_i;
                dec_op.regWrEnable = 1'b1;
                dec_op.isALUInImm  = 1'b1;
                dec_op.isJalr      = 1'b1;
            end
            OPC_BRANCH: begin
                dec_ill         = (f3 == 3'd2) || (f3 == 3'd3);
                dec_op.rs1      = f_rs1;
                dec_op.rs2      = f_rs2;
                dec_op.imm      = imm_b;
                dec_op.funct3   = f3;
                dec_op.isBranch = 1'b1;
            end
            OPC_LOAD: begin
                dec_ill            = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                dec_op.rd          = f_rd;
                dec_op.rs1         = f_rs1;
                dec_op.imm         = imm_i;
                dec_op.funct3      = f3;
                dec_op.regWrEnable = 1'b1;
                dec_op.isALUInImm  = 1'b1;
                dec_op.isLoad      = 1'b1;
            end
            OPC_STORE: begin
                dec_ill           = (f3 > 3'd2);
                dec_op.rs1        = f_rs1;
                dec_op.rs2        = f_rs2;
                dec_op.imm        = imm_s;
                dec_op.funct3     = f3;
                dec_op.isALUInImm = 1'b1;
                dec_op.isStore    = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_op.rd          = f_rd;
                dec_op.rs1         = f_rs1;
                dec_op.imm         = imm_i;
                dec_op.funct3      = f3;
                dec_op.regWrEnable = 1'b1;
                dec_op.isALUInImm  = 1'b1;
                // shifts carry shamt as the immediate and funct7 as a qualifier
                if (f3 == 3'd1) begin
                    dec_op.imm = imm_sh;
                    dec_ill    = (f7 != F7_BASE);
                end else if (f3 == 3'd5) begin
                    dec_op.imm    = imm_sh;
                    dec_op.aluAlt = (f7 == F7_ALT);
                    dec_ill       = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OPC_OP: begin
                dec_op.rd          = f_rd;
                dec_op.rs1         = f_rs1;
                dec_op.rs2         = f_rs2;
                dec_op.funct3      = f3;
                dec_op.regWrEnable = 1'b1;
                if (f7 == F7_BASE) begin
                    dec_ill = 1'b0;
                end else if (f7 == F7_ALT) begin
                    dec_op.aluAlt = 1'b1;
                    dec_ill       = (f3 != 3'd0) && (f3 != 3'd5);
                end else if ((f7 == F7_MUL) && (ENABLE_M != 0)) begin
                    dec_md = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                if ((ENABLE_SYSTEM != 0) && (f3 == 3'd0)) begin
                    dec_sys    = 1'b1;
                    dec_op.imm = imm_i;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if ((ENABLE_SYSTEM != 0) &&
                    ((head_insn == 32'h0000_0073) || (head_insn == 32'h0010_0073))) begin
                    dec_sys    = 1'b1;
                    dec_op.imm = imm_i;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
        if (head_insn[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end
        if (dec_ill) begin
            dec_op  = '0;
            dec_md  = 1'b0;
            dec_sys = 1'b0;
        end
    end

    // FIFO payload write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_insn[wr_ptr] <= bus.in_insn;
            mem_pc[wr_ptr]   <= bus.in_pc;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue ahead of any push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, load})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Output stage: capture a decoded head on load, retire on accept, hold when stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_pc_q    <= '0;
            out_ill_q   <= 1'b0;
            out_md_q    <= 1'b0;
            out_sys_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_op_q    <= dec_op;
            out_pc_q    <= head_pc;
            out_ill_q   <= dec_ill;
            out_md_q    <= dec_md;
            out_sys_q   <= dec_sys;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a full-featured instance and a reduced one
// (no RV32M, no SYSTEM) run in lockstep on the same stimulus.
module tb_decode_stage;

    localparam int OPW = 60;

    localparam logic [8:0] F_WR   = 9'b100000000;
    localparam logic [8:0] F_IMM  = 9'b010000000;
    localparam logic [8:0] F_LD   = 9'b001000000;
    localparam logic [8:0] F_ST   = 9'b000100000;
    localparam logic [8:0] F_BR   = 9'b000010000;
    localparam logic [8:0] F_JAL  = 9'b000001000;
    localparam logic [8:0] F_JALR = 9'b000000100;
    localparam logic [8:0] F_LUI  = 9'b000000010;
    localparam logic [8:0] F_AUI  = 9'b000000001;

    typedef struct packed {
        logic [31:0]    pc;
        logic [OPW-1:0] op;
        logic           ill;
        logic           md;
        logic           sys;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_insn = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;
    logic [2:0]  cnt0;
    logic [2:0]  cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;

    decode_stage_if #(.OPINFO_W(OPW)) b0 ();
    decode_stage_if #(.OPINFO_W(OPW)) b1 ();

    assign b0.in_valid  = in_valid;
    assign b0.in_insn   = in_insn;
    assign b0.in_pc     = in_pc;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.in_insn   = in_insn;
    assign b1.in_pc     = in_pc;
    assign b1.out_ready = out_ready;

    decode_stage #(.DEPTH(4), .ENABLE_M(1), .ENABLE_SYSTEM(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b0),
        .count (cnt0)
    );

    decode_stage #(.DEPTH(4), .ENABLE_M(0), .ENABLE_SYSTEM(0)) dut_min (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b1),
        .count (cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [OPW-1:0] op(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm,
                                          input logic [2:0] f3, input logic alt,
                                          input logic [8:0] fl);
        return {rd, rs1, rs2, imm, f3, alt, fl};
    endfunction

    function automatic exp_t good(input logic [OPW-1:0] o, input logic md, input logic sys);
        exp_t r;
        r     = '0;
        r.op  = o;
        r.md  = md;
        r.sys = sys;
        return r;
    endfunction

    function automatic exp_t illx();
        exp_t r;
        r     = '0;
        r.ill = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    function automatic exp_t addi_exp(input logic [4:0] rd, input logic [11:0] imm);
        return good(op(rd, 5'd0, 5'd0, {20'b0, imm}, 3'd0, 1'b0, F_WR | F_IMM), 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic mon(input string name, input exp_t a, input exp_t e, input bit have);
        total++;
        if (!have) begin
            bad++;
            $display("FAIL %s_unexpected: got pc=%h op=%h ill=%b, want no output", name, a.pc, a.op, a.ill);
        end else if (a !== e) begin
            bad++;
            $display("FAIL %s: got pc=%h op=%h ill=%b md=%b sys=%b want pc=%h op=%h ill=%b md=%b sys=%b",
                     name, a.pc, a.op, a.ill, a.md, a.sys, e.pc, e.op, e.ill, e.md, e.sys);
        end
    endtask

    // Offer one insn; expectations enter the scoreboards only once it is accepted
    task automatic send(input logic [31:0] insn, input logic [31:0] pc, input exp_t e0, input exp_t e1);
        int unsigned waited;
        waited   = 0;
        in_valid = 1'b1;
        in_insn  = insn;
        in_pc    = pc;
        @(negedge clk);
        while (!(b0.in_ready && b1.in_ready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!(b0.in_ready && b1.in_ready)) begin
            bad++;
            $display("FAIL send_timeout: in_ready=0 want 1 for pc=%h", pc);
            in_valid = 1'b0;
        end else begin
            e0.pc = pc;
            e1.pc = pc;
            q0.push_back(e0);
            q1.push_back(e1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for the full-featured instance
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        bit   h;
        if (!rst && b0.out_valid && b0.out_ready) begin
            a = {b0.out_pc, b0.out_opinfo, b0.out_illegal, b0.out_is_muldiv, b0.out_is_system};
            e = '0;
            h = (q0.size() != 0);
            if (h) e = q0.pop_front();
            mon("out_full", a, e, h);
        end
    end

    // Monitor for the reduced instance
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        bit   h;
        if (!rst && b1.out_valid && b1.out_ready) begin
            a = {b1.out_pc, b1.out_opinfo, b1.out_illegal, b1.out_is_muldiv, b1.out_is_system};
            e = '0;
            h = (q1.size() != 0);
            if (h) e = q1.pop_front();
            mon("out_min", a, e, h);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
        chk("rst_count", 64'(cnt0), 64'd0);
        chk("rst_count_min", 64'(cnt1), 64'd0);
        chk("rst_in_ready", 64'(b0.in_ready), 64'd1);
        chk("rst_opinfo", 64'(b0.out_opinfo), 64'd0);
        chk("rst_out_pc", 64'(b0.out_pc), 64'd0);
        chk("rst_flags", 64'({b0.out_illegal, b0.out_is_muldiv, b0.out_is_system}), 64'd0);

        // Single addi, one-cycle latency
        out_ready = 1'b1;
        send(32'h0050_0093, 32'h100,
             good(op(5'd1, 5'd0, 5'd0, 32'd5, 3'd0, 1'b0, F_WR | F_IMM), 1'b0, 1'b0),
             good(op(5'd1, 5'd0, 5'd0, 32'd5, 3'd0, 1'b0, F_WR | F_IMM), 1'b0, 1'b0));
        chk("lat_not_yet_valid", 64'(b0.out_valid), 64'd0);
        chk("lat_count", 64'(cnt0), 64'd1);
        cycles(1);
        chk("lat_valid", 64'(b0.out_valid), 64'd1);
        chk("lat_count_after", 64'(cnt0), 64'd0);
        cycles(2);

        // Fill to capacity with consumer stalled, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(addi(5'(i + 2), 12'(i + 10)), 32'(32'h200 + 4 * i),
                 addi_exp(5'(i + 2), 12'(i + 10)), addi_exp(5'(i + 2), 12'(i + 10)));
        end
        chk("full_count", 64'(cnt0), 64'd4);
        chk("full_in_ready", 64'(b0.in_ready), 64'd0);
        chk("full_out_valid", 64'(b0.out_valid), 64'd1);
        cycles(3);
        chk("stall_out_pc", 64'(b0.out_pc), 64'h200);
        chk("stall_opinfo", 64'(b0.out_opinfo), 64'(op(5'd2, 5'd0, 5'd0, 32'd10, 3'd0, 1'b0, F_WR | F_IMM)));
        chk("stall_count", 64'(cnt0), 64'd4);
        out_ready = 1'b1;
        cycles(5);
        chk("drain_q_full", 64'(q0.size()), 64'd0);
        chk("drain_q_min", 64'(q1.size()), 64'd0);
        chk("drain_out_valid", 64'(b0.out_valid), 64'd0);

        // Continuous streaming with two entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(addi(5'(i + 7), 12'(i + 40)), 32'(32'h300 + 4 * i),
                 addi_exp(5'(i + 7), 12'(i + 40)), addi_exp(5'(i + 7), 12'(i + 40)));
        end
        chk("pre_stream_count", 64'(cnt0), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(addi(5'(i + 10), 12'(i + 100)), 32'(32'h400 + 4 * i),
                 addi_exp(5'(i + 10), 12'(i + 100)), addi_exp(5'(i + 10), 12'(i + 100)));
            chk("stream_count", 64'(cnt0), 64'd2);
        end
        cycles(3);
        chk("stream_q_empty", 64'(q0.size() + q1.size()), 64'd0);
        chk("stream_out_valid", 64'(b0.out_valid), 64'd0);

        // Flush with buffered, output-stage and incoming insns
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(addi(5'(i + 1), 12'(i + 200)), 32'(32'h600 + 4 * i),
                 addi_exp(5'(i + 1), 12'(i + 200)), addi_exp(5'(i + 1), 12'(i + 200)));
        end
        chk("preflush_count", 64'(cnt0), 64'd3);
        chk("preflush_valid", 64'(b0.out_valid), 64'd1);
        in_valid = 1'b1;
        in_insn  = addi(5'd31, 12'd999);
        in_pc    = 32'h6FC;
        flush    = 1'b1;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
        chk("flush_count", 64'(cnt0), 64'd0);
        chk("flush_count_min", 64'(cnt1), 64'd0);
        chk("flush_out_valid", 64'(b0.out_valid), 64'd0);
        out_ready = 1'b1;
        send(addi(5'd4, 12'd44), 32'h700, addi_exp(5'd4, 12'd44), addi_exp(5'd4, 12'd44));
        cycles(2);
        chk("postflush_q_empty", 64'(q0.size() + q1.size()), 64'd0);

        // Decode vectors, full vs reduced configuration
        send(32'h0220_8033, 32'h800,
             good(op(5'd0, 5'd1, 5'd2, 32'd0, 3'd0, 1'b0, F_WR), 1'b1, 1'b0), illx());
        send(32'h0000_0073, 32'h804, good('0, 1'b0, 1'b1), illx());
        send(32'h0000_3003, 32'h808, illx(), illx());
        send(32'hFFFF_FFFF, 32'h80C, illx(), illx());
        send(32'h0010_0073, 32'h810,
             good(op(5'd0, 5'd0, 5'd0, 32'd1, 3'd0, 1'b0, 9'd0), 1'b0, 1'b1), illx());
        send(32'h4020_81B3, 32'h814,
             good(op(5'd3, 5'd1, 5'd2, 32'd0, 3'd0, 1'b1, F_WR), 1'b0, 1'b0),
             good(op(5'd3, 5'd1, 5'd2, 32'd0, 3'd0, 1'b1, F_WR), 1'b0, 1'b0));
        send(32'hFE20_8EE3, 32'h818,
             good(op(5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 3'd0, 1'b0, F_BR), 1'b0, 1'b0),
             good(op(5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 3'd0, 1'b0, F_BR), 1'b0, 1'b0));
        send(32'h4010_D093, 32'h81C,
             good(op(5'd1, 5'd1, 5'd0, 32'd1, 3'd5, 1'b1, F_WR | F_IMM), 1'b0, 1'b0),
             good(op(5'd1, 5'd1, 5'd0, 32'd1, 3'd5, 1'b1, F_WR | F_IMM), 1'b0, 1'b0));
        send(32'h4010_9093, 32'h820, illx(), illx());
        send(32'h1234_52B7, 32'h824,
             good(op(5'd5, 5'd0, 5'd0, 32'h1234_5000, 3'd0, 1'b0, F_WR | F_IMM | F_LUI), 1'b0, 1'b0),
             good(op(5'd5, 5'd0, 5'd0, 32'h1234_5000, 3'd0, 1'b0, F_WR | F_IMM | F_LUI), 1'b0, 1'b0));
        send(32'h0FF0_000F, 32'h828,
             good(op(5'd0, 5'd0, 5'd0, 32'h0FF, 3'd0, 1'b0, 9'd0), 1'b0, 1'b1), illx());
        send(32'h0020_A423, 32'h82C,
             good(op(5'd0, 5'd1, 5'd2, 32'd8, 3'd2, 1'b0, F_ST | F_IMM), 1'b0, 1'b0),
             good(op(5'd0, 5'd1, 5'd2, 32'd8, 3'd2, 1'b0, F_ST | F_IMM), 1'b0, 1'b0));
        send(32'h0100_00EF, 32'h830,
             good(op(5'd1, 5'd0, 5'd0, 32'd16, 3'd0, 1'b0, F_WR | F_JAL), 1'b0, 1'b0),
             good(op(5'd1, 5'd0, 5'd0, 32'd16, 3'd0, 1'b0, F_WR | F_JAL), 1'b0, 1'b0));
        send(32'h0420_8033, 32'h834, illx(), illx());
        cycles(3);
        chk("final_q_full", 64'(q0.size()), 64'd0);
        chk("final_q_min", 64'(q1.size()), 64'd0);
        chk("final_out_valid", 64'(b0.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
